// File: rtl/uop_fetch_queue.sv
// uop_fetch_queue
// Fetches FETCH_WIDTH-lane bundles from the uop buffer one read at a time.
// Returned bundles are branch-tagged and held in a QUEUE_DEPTH-entry FIFO.
// Decode takes them from the FIFO with a valid/stall handshake.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              upstream permission to fetch
//   uop_addr, uop_rd    buffer read address (bundle base) and read strobe
//   uop_data            buffer read data, valid the cycle after uop_rd
//   redirect_*          flush the queue, restart fetch at a new address/tag
//   next_stalled        decode cannot accept the head bundle
//   valid, stalled      head bundle present / FIFO full
//   out_instr, out_tag  head bundle lanes (lane 0 in LSBs) and per-lane tags
//   out_addr            head bundle base address
module uop_fetch_queue #(
  parameter int         UOP_BUF_SIZE = 256,
  parameter int         FETCH_WIDTH  = 2,
  parameter int         QUEUE_DEPTH  = 4,
  parameter int         INSTR_W      = 32,
  parameter int         TAG_W        = 3,
  parameter logic [3:0] BRANCH_OPC   = 4'hB,
  localparam int        AW           = $clog2(UOP_BUF_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  output logic [AW-1:0]                  uop_addr,
  output logic                           uop_rd,
  input  logic [FETCH_WIDTH*INSTR_W-1:0] uop_data,
  input  logic                           redirect_valid,
  input  logic [AW-1:0]                  redirect_addr,
  input  logic [TAG_W-1:0]               redirect_tag,
  input  logic                           next_stalled,
  output logic                           valid,
  output logic                           stalled,
  output logic [FETCH_WIDTH*INSTR_W-1:0] out_instr,
  output logic [FETCH_WIDTH*TAG_W-1:0]   out_tag,
  output logic [AW-1:0]                  out_addr
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int BW = FETCH_WIDTH * INSTR_W;
  localparam int GW = FETCH_WIDTH * TAG_W;

  logic [AW-1:0]    pc_r;
  logic [TAG_W-1:0] tag_ctr_r;
  logic [CW-1:0]    count_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic             inflight_r;
  logic [AW-1:0]    infl_addr_r;
  logic             valid_r;
  logic             stalled_r;

  logic [BW-1:0]    q_instr_r [QUEUE_DEPTH];
  logic [GW-1:0]    q_tag_r   [QUEUE_DEPTH];
  logic [AW-1:0]    q_addr_r  [QUEUE_DEPTH];

  logic             credit_ok_s;
  logic             rd_s;
  logic             enq_s;
  logic             deq_s;
  logic [CW-1:0]    count_next_s;
  logic [AW:0]      pc_sum_s;
  logic [AW-1:0]    pc_next_s;
  logic [TAG_W-1:0] tag_acc_s;
  logic [GW-1:0]    lane_tag_s;

  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == BRANCH_OPC;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(QUEUE_DEPTH - 1)) r = '0;
    else                           r = p + PW'(1);
    return r;
  endfunction

  // The in-flight read already owns a slot, so it is counted as occupied.
  assign credit_ok_s = ((CW+1)'(count_r) + (CW+1)'(inflight_r)) < (CW+1)'(QUEUE_DEPTH);
  // Gating with reset makes the strobe drop the moment reset rises.
  assign rd_s        = !reset && enable && !redirect_valid && credit_ok_s;
  assign enq_s       = inflight_r && !redirect_valid;
  assign deq_s       = valid_r && !next_stalled && !redirect_valid;

  assign uop_rd    = rd_s;
  assign uop_addr  = pc_r;
  assign valid     = valid_r;
  assign stalled   = stalled_r;
  assign out_instr = q_instr_r[head_r];
  assign out_tag   = q_tag_r[head_r];
  assign out_addr  = q_addr_r[head_r];

  // Next fetch address, wrapping at the end of the uop buffer.
  always_comb begin
    pc_sum_s = {1'b0, pc_r} + (AW+1)'(FETCH_WIDTH);
    if (pc_sum_s >= (AW+1)'(UOP_BUF_SIZE)) pc_next_s = AW'(pc_sum_s - (AW+1)'(UOP_BUF_SIZE));
    else                                   pc_next_s = pc_sum_s[AW-1:0];
  end

  // Per-lane tags: each lane sees the counter plus the branches in lower lanes.
  always_comb begin
    tag_acc_s  = tag_ctr_r;
    lane_tag_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_tag_s[i*TAG_W +: TAG_W] = tag_acc_s;
      if (is_branch(uop_data[i*INSTR_W +: INSTR_W])) tag_acc_s = tag_acc_s + TAG_W'(1);
      else                                           tag_acc_s = tag_acc_s;
    end
  end

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    case ({enq_s, deq_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Fetch control, FIFO pointers and the registered handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r        <= '0;
      tag_ctr_r   <= '0;
      count_r     <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      inflight_r  <= 1'b0;
      infl_addr_r <= '0;
      valid_r     <= 1'b0;
      stalled_r   <= 1'b0;
    end else if (redirect_valid) begin
      pc_r       <= redirect_addr;
      tag_ctr_r  <= redirect_tag;
      count_r    <= '0;
      head_r     <= '0;
      tail_r     <= '0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      stalled_r  <= 1'b0;
    end else begin
      if (rd_s) begin
        pc_r        <= pc_next_s;
        infl_addr_r <= pc_r;
      end
      inflight_r <= rd_s;
      if (enq_s) begin
        tail_r    <= ptr_inc(tail_r);
        tag_ctr_r <= tag_acc_s;
      end
      if (deq_s) head_r <= ptr_inc(head_r);
      count_r   <= count_next_s;
      valid_r   <= (count_next_s != CW'(0));
      stalled_r <= (count_next_s == CW'(QUEUE_DEPTH));
    end
  end

  // Bundle storage; entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_instr_r[tail_r] <= uop_data;
      q_tag_r[tail_r]   <= lane_tag_s;
      q_addr_r[tail_r]  <= infl_addr_r;
    end
  end

endmodule

// File: tb/tb_uop_fetch_queue.sv
module tb_uop_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  uop_addr;
  logic        uop_rd;
  logic [63:0] uop_data = 64'd0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = 8'd0;
  logic [2:0]  redirect_tag = 3'd0;
  logic        next_stalled = 1'b0;
  logic        valid;
  logic        stalled;
  logic [63:0] out_instr;
  logic [5:0]  out_tag;
  logic [7:0]  out_addr;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];

  uop_fetch_queue #(
    .UOP_BUF_SIZE(256), .FETCH_WIDTH(2), .QUEUE_DEPTH(4),
    .INSTR_W(32), .TAG_W(3), .BRANCH_OPC(4'hB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .uop_addr(uop_addr), .uop_rd(uop_rd), .uop_data(uop_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .redirect_tag(redirect_tag), .next_stalled(next_stalled),
    .valid(valid), .stalled(stalled), .out_instr(out_instr),
    .out_tag(out_tag), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // uop buffer model: one-cycle read latency, lanes wrap at the buffer end
  always @(posedge clk) begin
    if (uop_rd) uop_data <= {mem[uop_addr + 8'd1], mem[uop_addr]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [63:0] instr;
    logic [5:0]  tag;
  } bundle_t;

  bundle_t     mq[$];
  bundle_t     nb;
  bit          m_infl;
  logic [7:0]  m_infl_addr;
  logic [7:0]  m_pc;
  logic [2:0]  m_tag;
  logic [2:0]  t0;
  logic [2:0]  t1;
  bit          exp_rd;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = 8'd0;
      m_tag  = 3'd0;
    end else begin
      exp_rd = enable && !redirect_valid && ((mq.size() + int'(m_infl)) < 4);
      chk("mon_rd", uop_rd, exp_rd);
      if (exp_rd) chk("mon_addr", uop_addr, m_pc);
      chk("mon_valid", valid, mq.size() != 0);
      chk("mon_stalled", stalled, mq.size() == 4);
      if (mq.size() != 0) begin
        chk("mon_out_addr", out_addr, mq[0].addr);
        chk("mon_out_instr", out_instr, mq[0].instr);
        chk("mon_out_tag", out_tag, mq[0].tag);
      end
      if (redirect_valid) begin
        mq.delete();
        m_infl = 1'b0;
        m_pc   = redirect_addr;
        m_tag  = redirect_tag;
      end else begin
        if (mq.size() != 0 && !next_stalled) void'(mq.pop_front());
        if (m_infl) begin
          nb.addr  = m_infl_addr;
          nb.instr = {mem[m_infl_addr + 8'd1], mem[m_infl_addr]};
          t0 = m_tag;
          t1 = (mem[m_infl_addr][31:28] == 4'hB) ? t0 + 3'd1 : t0;
          m_tag = (mem[m_infl_addr + 8'd1][31:28] == 4'hB) ? t1 + 3'd1 : t1;
          nb.tag = {t1, t0};
          mq.push_back(nb);
        end
        if (exp_rd) begin
          m_infl_addr = m_pc;
          m_pc = m_pc + 8'd2;
        end
        m_infl = exp_rd;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  // leaves the bench at the drive point of cycle 0 with reset released
  task automatic do_reset(input bit branch_mem);
    @(posedge clk); #1;
    reset = 1'b1; enable = 1'b0; next_stalled = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 8'd0; redirect_tag = 3'd0;
    mem[1] = branch_mem ? 32'hB000_0001 : 32'd1;
    mem[2] = branch_mem ? 32'hB000_0002 : 32'd2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       ns;
    logic       rd;
    logic [7:0] addr;
    logic       vld;
    logic       stl;
    logic [7:0] head;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'(k);

    // backpressure table: one row per cycle after reset release
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 8'h02};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h04};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 8'h06};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h0E, 1'b1, 1'b0, 8'h08};

    // reset state
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_stalled", stalled, 1'b0);
    chk("rst_rd", uop_rd, 1'b0);
    chk("rst_addr", uop_addr, 8'd0);

    // basic streaming
    do_reset(1'b0);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("A_rd", uop_rd, 1'b1);
      chk("A_addr", uop_addr, 64'(2 * c));
      if (c >= 2) begin
        chk("A_valid", valid, 1'b1);
        chk("A_out_addr", out_addr, 64'(2 * (c - 2)));
        chk("A_out_instr", out_instr, {32'(2 * (c - 2) + 1), 32'(2 * (c - 2))});
      end else begin
        chk("A_valid_early", valid, 1'b0);
      end
    end

    // backpressure / full, table driven
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      enable = tbl[i].en;
      next_stalled = tbl[i].ns;
      @(negedge clk);
      chk("B_rd", uop_rd, tbl[i].rd);
      if (tbl[i].rd) chk("B_addr", uop_addr, tbl[i].addr);
      chk("B_valid", valid, tbl[i].vld);
      chk("B_stalled", stalled, tbl[i].stl);
      if (tbl[i].vld) chk("B_head", out_addr, tbl[i].head);
    end

    // branch tagging
    do_reset(1'b1);
    enable = 1'b1;
    @(negedge clk);
    step();
    step();
    chk("C_addr0", out_addr, 8'h00);
    chk("C_tag0", out_tag, {3'd0, 3'd0});
    step();
    chk("C_addr2", out_addr, 8'h02);
    chk("C_tag2", out_tag, {3'd2, 3'd1});
    step();
    chk("C_addr4", out_addr, 8'h04);
    chk("C_tag4", out_tag, {3'd2, 3'd2});

    // redirect with a read in flight
    do_reset(1'b0);
    enable = 1'b1;
    @(negedge clk);
    step();
    step();
    step();
    chk("D_addr6", uop_addr, 8'h06);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_addr = 8'h40; redirect_tag = 3'd5;
    @(negedge clk);
    chk("D_rd_in_redirect", uop_rd, 1'b0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("D_valid_after", valid, 1'b0);
    chk("D_rd_after", uop_rd, 1'b1);
    chk("D_addr_after", uop_addr, 8'h40);
    step();
    chk("D_valid_gap", valid, 1'b0);
    step();
    chk("D_valid_new", valid, 1'b1);
    chk("D_out_addr", out_addr, 8'h40);
    chk("D_out_instr", out_instr, {32'h41, 32'h40});
    chk("D_out_tag", out_tag, {3'd5, 3'd5});
    step();
    chk("D_out_addr_next", out_addr, 8'h42);

    // wrap at the end of the buffer
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_addr = 8'hFF; redirect_tag = 3'd0;
    @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("E_addr_ff", uop_addr, 8'hFF);
    step();
    chk("E_addr_01", uop_addr, 8'h01);
    step();
    chk("E_valid", valid, 1'b1);
    chk("E_out_addr", out_addr, 8'hFF);
    chk("E_out_instr", out_instr, {32'd0, 32'd255});

    // asynchronous reset with three bundles queued
    do_reset(1'b0);
    enable = 1'b1; next_stalled = 1'b1;
    @(negedge clk);
    step();
    step();
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    repeat (3) step();
    @(posedge clk); #1;
    enable = 1'b1;
    #1;
    chk("F_rd_before", uop_rd, 1'b1);
    chk("F_valid_before", valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("F_valid_async", valid, 1'b0);
    chk("F_stalled_async", stalled, 1'b0);
    chk("F_rd_async", uop_rd, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; next_stalled = 1'b0;
    @(negedge clk);
    chk("F_rd_restart", uop_rd, 1'b1);
    chk("F_addr_restart", uop_addr, 8'h00);
    step();
    step();
    chk("F_valid_restart", valid, 1'b1);
    chk("F_out_addr", out_addr, 8'h00);
    chk("F_out_tag", out_tag, {3'd0, 3'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uop_fetch_queue.md
Name: uop_fetch_queue

Overview:
- Parametrised successor to the two-wide microcode fetch stage.
- Generalised to FETCH_WIDTH lanes per bundle. Issues sequential reads to the uop buffer and queues returned bundles in a QUEUE_DEPTH-entry FIFO.
- Tags each lane with a running branch tag, supports redirect/flush, and hands bundles to decode with a valid/stall handshake.

Parameters:
- UOP_BUF_SIZE, 256, uop buffer entries; address width AW = $clog2(UOP_BUF_SIZE).
- FETCH_WIDTH, 2, lanes per bundle; power of two, 1..8.
- QUEUE_DEPTH, 4, bundle entries in the FIFO; 2..16.
- INSTR_W, 32, bits per uop.
- TAG_W, 3, branch tag width.
- BRANCH_OPC, 4'hB, value of instr[INSTR_W-1 -: 4] that marks a branch.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  upstream permission to fetch (prev_valid)
- uop_addr  out  AW  buffer read address, bundle base
- uop_rd  out  1  read strobe
- uop_data  in  FETCH_WIDTH*INSTR_W  buffer data; lane i = buf[(addr+i) mod UOP_BUF_SIZE]; valid the cycle after uop_rd
- redirect_valid  in  1  flush and refetch
- redirect_addr  in  AW  new fetch address
- redirect_tag  in  TAG_W  tag counter value after redirect
- next_stalled  in  1  decode cannot accept
- valid  out  1  head bundle present
- stalled  out  1  FIFO full
- out_instr  out  FETCH_WIDTH*INSTR_W  head bundle, lane 0 in LSBs
- out_tag  out  FETCH_WIDTH*TAG_W  per-lane branch tags
- out_addr  out  AW  head bundle base address

Behaviour:
- Reset values (asynchronous): pc=0, tag_ctr=0, count=0, head=tail=0, inflight=0, uop_rd=0, valid=0, stalled=0. uop_addr=0.
- Read issue: uop_rd = enable && !redirect_valid && (count+inflight < QUEUE_DEPTH). uop_addr = pc (combinational).
  - On issue: pc <= (pc+FETCH_WIDTH) mod UOP_BUF_SIZE. inflight <= 1, and holds the issued address.
- Return: the cycle after issue, if inflight and no redirect, the bundle is enqueued at tail with its address.
  - Tagging: lane i gets tag_ctr + (number of branch lanes j<i). tag_ctr advances by the bundle's branch count, mod 2^TAG_W.
- Latency: uop_rd in cycle N -> valid=1 with that bundle in cycle N+2 if the FIFO was empty.
- Dequeue: in a cycle where valid && !next_stalled, the head pops at the clock edge.
  - Simultaneous enqueue and dequeue keeps count unchanged.
  - Sustained throughput is one bundle per cycle when next_stalled=0.
- valid = (count!=0). stalled = (count==QUEUE_DEPTH).
- Output fields are stable while valid && next_stalled.
- Full: no read issues. The credit check counts the in-flight read, so a return never overflows the FIFO.
- Pointer wrap: head/tail wrap mod QUEUE_DEPTH. pc wraps mod UOP_BUF_SIZE; a bundle may straddle the buffer end.
- Redirect (highest priority):
  - In the redirect cycle: no read issues, and no enqueue or dequeue takes effect.
  - At the edge: count=0, head=tail=0, inflight=0 (pending return discarded), pc=redirect_addr, tag_ctr=redirect_tag. valid=0 next cycle.
  - First read from redirect_addr issues the cycle after redirect (if enable).
- enable=0: no new reads. In-flight return still enqueues, and the queue drains normally.
- Reset mid-operation: all state cleared immediately, including any in-flight read.

Test Plan:
- Basic streaming:
  - Stimulus: reset, enable=1, next_stalled=0, FETCH_WIDTH=2, buf[k]=k.
  - Required: uop_addr 0,2,4… on consecutive cycles; first valid two cycles after first uop_rd with out_instr lanes {0,1}, out_addr=0; then one bundle per cycle.
- Backpressure/full:
  - Stimulus: next_stalled=1 from cycle 0, QUEUE_DEPTH=4.
  - Required: exactly 4 reads issue, stalled=1, uop_rd=0 thereafter, head stays out_addr=0.
  - Release next_stalled: addresses 0,2,4,6 drain in order, fetch resumes at 8.
- Branch tagging:
  - Stimulus: buf[1] and buf[2] are branches (top nibble 4'hB), tag_ctr=0.
  - Required: bundle@0 tags {0,0}, bundle@2 tags {1,2}, bundle@4 tags {2,2}.
- Redirect with in-flight read:
  - Stimulus: assert redirect_valid (addr=0x40, tag=5) the cycle after a read to 0x06.
  - Required: 0x06 data never appears, valid=0 next cycle, next uop_addr=0x40, its tags start at 5.
- Wrap:
  - Stimulus: UOP_BUF_SIZE=256, redirect to 0xFF.
  - Required: bundle has out_addr=0xFF with lanes {buf[255],buf[0]}, next read addr=0x01.
- Async reset mid-stream:
  - Stimulus: assert reset with count=3.
  - Required: valid, stalled and uop_rd fall without a clock edge. After release, fetch restarts at addr 0 with tag 0.
